// File: rtl/ext_intr_ctrl.sv
// Machine-level external interrupt controller: synchronizes NUM_SRC async lines,
// latches edge/level pending, picks a fixed-priority winner and tracks one in-service claim.
module ext_intr_ctrl #(
  parameter int NUM_SRC    = 8,
  parameter int CAUSE_BASE = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               claim_i,
  input  logic               bus_wr_i,
  input  logic [3:0]         bus_addr_i,
  input  logic [31:0]        bus_wdata_i,
  output logic [31:0]        bus_rdata_o,
  output logic               m_ext_intr_o,
  output logic [30:0]        mcause_o,
  output logic               in_service_o
);

  typedef enum logic {IDLE, SERVICE} state_t;

  state_t             state;
  logic [NUM_SRC-1:0] s1, s2, s3;
  logic [NUM_SRC-1:0] pending, enable, edge_sel;
  logic [NUM_SRC-1:0] req, edge_evt, w1c, claim_clr, pending_next;
  logic [4:0]         id, winner;
  logic [1:0]         reg_sel;
  logic               any_req, claim_take, complete_hit;
  logic               unused;

  assign unused     = ^{bus_addr_i[1:0], bus_wdata_i};
  assign reg_sel    = bus_addr_i[3:2];
  assign edge_evt   = s2 & ~s3;
  assign req        = pending & enable;
  assign any_req    = |req;
  assign claim_take = (state == IDLE) && claim_i && any_req;
  assign complete_hit = bus_wr_i && (reg_sel == 2'd3) && (state == SERVICE) &&
                        (bus_wdata_i[4:0] == id);
  assign w1c = (bus_wr_i && (reg_sel == 2'd1)) ? bus_wdata_i[NUM_SRC-1:0] : '0;
  assign in_service_o = (state == SERVICE);

  // Lowest index wins; scanning downward leaves the lowest set bit last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) winner = 5'(i);
    end
  end

  // Edge bits: a fresh edge beats a same-cycle clear. Level bits follow s2.
  always_comb begin
    claim_clr    = '0;
    pending_next = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      claim_clr[i] = claim_take && edge_sel[i] && (winner == 5'(i));
      if (edge_sel[i]) begin
        pending_next[i] = (pending[i] & ~(claim_clr[i] | w1c[i])) | edge_evt[i];
      end else begin
        pending_next[i] = s2[i];
      end
    end
  end

  always_comb begin
    bus_rdata_o = '0;
    case (reg_sel)
      2'd0: bus_rdata_o = 32'(enable);
      2'd1: bus_rdata_o = 32'(pending);
      2'd2: bus_rdata_o = 32'(edge_sel);
      default: bus_rdata_o = {in_service_o, 26'b0, id};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1           <= '0;
      s2           <= '0;
      s3           <= '0;
      pending      <= '0;
      enable       <= '0;
      edge_sel     <= '0;
      state        <= IDLE;
      id           <= '0;
      m_ext_intr_o <= 1'b0;
      mcause_o     <= '0;
    end else begin
      s1      <= src_i;
      s2      <= s1;
      s3      <= s2;
      pending <= pending_next;
      if (bus_wr_i && (reg_sel == 2'd0)) enable   <= bus_wdata_i[NUM_SRC-1:0];
      if (bus_wr_i && (reg_sel == 2'd2)) edge_sel <= bus_wdata_i[NUM_SRC-1:0];
      case (state)
        IDLE: begin
          m_ext_intr_o <= any_req;
          mcause_o     <= any_req ? (31'(CAUSE_BASE) + 31'(winner)) : '0;
          if (claim_take) begin
            state        <= SERVICE;
            id           <= winner;
            m_ext_intr_o <= 1'b0;
          end
        end
        default: begin
          // mcause_o holds the claimed code until completion.
          m_ext_intr_o <= 1'b0;
          if (complete_hit) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_intr_ctrl.sv
// Directed bench for ext_intr_ctrl: drivers push expectations into a queue,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_ext_intr_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  src_i = '0;
  logic        claim_i = 1'b0;
  logic        bus_wr_i = 1'b0;
  logic [3:0]  bus_addr_i = '0;
  logic [31:0] bus_wdata_i = '0;
  logic [31:0] bus_rdata_o;
  logic        m_ext_intr_o;
  logic [30:0] mcause_o;
  logic        in_service_o;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  int          tests = 0;
  int          fails = 0;

  localparam int SEL_MEXT = 0, SEL_CAUSE = 1, SEL_INSV = 2, SEL_RDATA = 3;

  ext_intr_ctrl #(.NUM_SRC(8), .CAUSE_BASE(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .src_i(src_i), .claim_i(claim_i),
    .bus_wr_i(bus_wr_i), .bus_addr_i(bus_addr_i), .bus_wdata_i(bus_wdata_i),
    .bus_rdata_o(bus_rdata_o), .m_ext_intr_o(m_ext_intr_o), .mcause_o(mcause_o),
    .in_service_o(in_service_o)
  );

  // Clock / watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] observe(int sel);
    case (sel)
      SEL_MEXT:  return 32'(m_ext_intr_o);
      SEL_CAUSE: return 32'(mcause_o);
      SEL_INSV:  return 32'(in_service_o);
      default:   return bus_rdata_o;
    endcase
  endfunction

  // Monitor / scoreboard
  always @(negedge clk_i) begin : monitor
    logic [31:0] e, a;
    int          s;
    string       n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      a = observe(s);
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", n, a, e);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_out(input int sel, input logic [31:0] val, input string name);
    sel_q.push_back(sel);
    exp_q.push_back(val);
    name_q.push_back(name);
  endtask

  task automatic chk_reg(input logic [1:0] idx, input logic [31:0] val, input string name);
    bus_addr_i = {idx, 2'b00};
    expect_out(SEL_RDATA, val, name);
    tick();
  endtask

  task automatic bus_write(input logic [1:0] idx, input logic [31:0] data);
    bus_wr_i    = 1'b1;
    bus_addr_i  = {idx, 2'b00};
    bus_wdata_i = data;
    tick();
    bus_wr_i    = 1'b0;
  endtask

  task automatic do_claim();
    claim_i = 1'b1;
    tick();
    claim_i = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    expect_out(SEL_MEXT, 0, "rst_mext");
    expect_out(SEL_CAUSE, 0, "rst_mcause");
    expect_out(SEL_INSV, 0, "rst_insv");
    chk_reg(2'd0, 32'h0, "rst_enable");
    chk_reg(2'd1, 32'h0, "rst_pending");
    chk_reg(2'd2, 32'h0, "rst_edge_sel");
    chk_reg(2'd3, 32'h0, "rst_claim");
    rst_ni = 1'b1;
    tick();

    // Edge source 2, one-cycle pulse, four-edge latency
    bus_write(2'd0, 32'h04);
    bus_write(2'd2, 32'h04);
    chk_reg(2'd2, 32'h04, "edge_sel_rb");
    src_i = 8'h04;
    tick();
    src_i = 8'h00;
    tick();
    tick();
    expect_out(SEL_MEXT, 0, "edge_mext_edge3");
    tick();
    expect_out(SEL_MEXT, 1, "edge_mext_edge4");
    expect_out(SEL_CAUSE, 18, "edge_mcause");
    do_claim();
    expect_out(SEL_MEXT, 0, "edge_claim_mext");
    expect_out(SEL_INSV, 1, "edge_claim_insv");
    expect_out(SEL_CAUSE, 18, "edge_claim_mcause");
    chk_reg(2'd1, 32'h00, "edge_claim_pending");
    chk_reg(2'd3, 32'h8000_0002, "edge_claim_reg");
    bus_write(2'd3, 32'd2);
    expect_out(SEL_INSV, 0, "edge_complete_insv");
    tick();
    expect_out(SEL_CAUSE, 0, "edge_idle_mcause");
    expect_out(SEL_MEXT, 0, "edge_idle_mext");
    tick();

    // Priority between level sources 5 and 1
    bus_write(2'd2, 32'h00);
    bus_write(2'd0, 32'hFF);
    src_i = 8'h22;
    repeat (4) tick();
    expect_out(SEL_MEXT, 1, "prio_mext");
    expect_out(SEL_CAUSE, 17, "prio_mcause");
    do_claim();
    expect_out(SEL_INSV, 1, "prio_claim_insv");
    expect_out(SEL_MEXT, 0, "prio_claim_mext");
    do_claim();
    expect_out(SEL_INSV, 1, "prio_reclaim_insv");
    expect_out(SEL_CAUSE, 17, "prio_reclaim_mcause");
    bus_write(2'd3, 32'd3);
    expect_out(SEL_INSV, 1, "prio_bad_complete");
    chk_reg(2'd3, 32'h8000_0001, "prio_claim_reg");
    bus_write(2'd3, 32'd1);
    expect_out(SEL_INSV, 0, "prio_complete_insv");
    expect_out(SEL_MEXT, 0, "prio_complete_mext");
    tick();
    expect_out(SEL_MEXT, 1, "prio_reassert_mext");
    expect_out(SEL_CAUSE, 17, "prio_reassert_mcause");
    src_i = 8'h00;
    repeat (4) tick();
    expect_out(SEL_MEXT, 0, "prio_drop_mext");
    tick();

    // Disabled source still latches pending
    bus_write(2'd0, 32'h00);
    bus_write(2'd2, 32'h01);
    src_i = 8'h01;
    tick();
    src_i = 8'h00;
    repeat (3) tick();
    expect_out(SEL_MEXT, 0, "dis_mext");
    chk_reg(2'd1, 32'h01, "dis_pending");
    bus_write(2'd0, 32'h01);
    expect_out(SEL_MEXT, 0, "dis_enable_edge1");
    tick();
    expect_out(SEL_MEXT, 1, "dis_enable_edge2");
    expect_out(SEL_CAUSE, 16, "dis_mcause");
    do_claim();
    bus_write(2'd3, 32'd0);
    tick();

    // W1C racing a fresh edge on source 3
    bus_write(2'd0, 32'h00);
    bus_write(2'd2, 32'h08);
    src_i = 8'h08;
    tick();
    src_i = 8'h00;
    tick();
    tick();
    chk_reg(2'd1, 32'h08, "w1c_first_pending");
    src_i = 8'h08;
    tick();
    src_i = 8'h00;
    tick();
    bus_write(2'd1, 32'h08);
    chk_reg(2'd1, 32'h08, "w1c_vs_edge");
    bus_write(2'd1, 32'h08);
    chk_reg(2'd1, 32'h00, "w1c_plain");

    // Spurious claim with no request
    bus_write(2'd0, 32'hFF);
    do_claim();
    expect_out(SEL_INSV, 0, "spur_insv");
    expect_out(SEL_MEXT, 0, "spur_mext");
    tick();

    // Async reset while in service
    bus_write(2'd2, 32'h00);
    bus_write(2'd0, 32'h01);
    src_i = 8'h01;
    repeat (4) tick();
    expect_out(SEL_MEXT, 1, "rsv_mext");
    expect_out(SEL_CAUSE, 16, "rsv_mcause");
    do_claim();
    expect_out(SEL_INSV, 1, "rsv_insv");
    tick();
    #2;
    rst_ni = 1'b0;
    src_i  = 8'h00;
    #1;
    expect_out(SEL_MEXT, 0, "rsv_async_mext");
    expect_out(SEL_CAUSE, 0, "rsv_async_mcause");
    expect_out(SEL_INSV, 0, "rsv_async_insv");
    tick();
    rst_ni = 1'b1;
    tick();
    chk_reg(2'd0, 32'h0, "rsv_enable");
    chk_reg(2'd1, 32'h0, "rsv_pending");
    chk_reg(2'd3, 32'h0, "rsv_claim_reg");

    // Final report
    tick();
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
